// File: rtl/bcd_display_ctrl.sv
// Sequencer between a CPU display register and a shared binary-to-BCD converter,
// with a scanned common-anode seven-segment display and leading-zero blanking.
module bcd_display_ctrl #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter bit          BLANK_LZ   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [31:0]           req_data,
  output logic                  req_ready,
  output logic [31:0]           conv_bin,
  input  logic [39:0]           conv_bcd,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  ovf
);

  localparam int unsigned IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

  state_t                  state, state_nx;
  logic [31:0]             bin_q;
  logic [4*NUM_DIGITS-1:0] disp_bcd;
  logic                    ovf_nx;
  logic [DIVW-1:0]         div;
  logic [IDXW-1:0]         idx;
  logic [3:0]              nib;
  logic                    upper_nz;
  logic                    blank;
  logic [6:0]              seg_nx;

  assign conv_bin = bin_q;

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = SETTLE;
      end
      SETTLE:  state_nx = CAPTURE;
      CAPTURE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Any converter digit beyond the physical display means the value cannot be shown.
  always_comb begin
    ovf_nx = 1'b0;
    for (int unsigned k = 0; k < 10; k++) begin
      if (k >= NUM_DIGITS) ovf_nx = ovf_nx | (|conv_bcd[4*k +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bin_q    <= '0;
      disp_bcd <= '0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) bin_q <= req_data;
      if (state == CAPTURE) begin
        disp_bcd <= conv_bcd[4*NUM_DIGITS-1:0];
        ovf      <= ovf_nx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      idx <= '0;
    end else if (div == DIVW'(SCAN_DIV - 1)) begin
      div <= '0;
      idx <= (idx == IDXW'(NUM_DIGITS - 1)) ? '0 : idx + IDXW'(1);
    end else begin
      div <= div + DIVW'(1);
    end
  end

  // Digit idx is blank when it and every more-significant digit are zero.
  always_comb begin
    nib      = '0;
    upper_nz = 1'b0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      if (IDXW'(j) == idx) nib = disp_bcd[4*j +: 4];
      if (j >= 32'(idx) && disp_bcd[4*j +: 4] != 4'd0) upper_nz = 1'b1;
    end
    blank = BLANK_LZ && (idx != '0) && !upper_nz;

    seg_nx = 7'h3F;
    if (ovf) begin
      seg_nx = 7'h3F;
    end else if (blank) begin
      seg_nx = 7'h7F;
    end else begin
      case (nib)
        4'd0:    seg_nx = 7'h40;
        4'd1:    seg_nx = 7'h79;
        4'd2:    seg_nx = 7'h24;
        4'd3:    seg_nx = 7'h30;
        4'd4:    seg_nx = 7'h19;
        4'd5:    seg_nx = 7'h12;
        4'd6:    seg_nx = 7'h02;
        4'd7:    seg_nx = 7'h78;
        4'd8:    seg_nx = 7'h00;
        4'd9:    seg_nx = 7'h10;
        default: seg_nx = 7'h3F;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= 7'h7F;
    end else begin
      an  <= ~(NUM_DIGITS'(1) << idx);
      seg <= seg_nx;
    end
  end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Bench for bcd_display_ctrl: two instances (blanking on/off) fed by a behavioural
// converter, checked every cycle against a spec-level scan/handshake model.
module tb_bcd_display_ctrl;

  localparam int unsigned ND = 8;
  localparam int unsigned SD = 4;
  localparam logic [6:0] SEGTAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                         7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic [31:0]   req_data;
  logic          req_ready_a, req_ready_b;
  logic [31:0]   conv_bin_a, conv_bin_b;
  logic [39:0]   conv_bcd_a, conv_bcd_b;
  logic [ND-1:0] an_a, an_b;
  logic [6:0]    seg_a, seg_b;
  logic          ovf_a, ovf_b;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [39:0] bin2bcd(input logic [31:0] b);
    longint unsigned v;
    logic [39:0]     r;
    v = 64'(b);
    r = '0;
    for (int d = 0; d < 10; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  assign conv_bcd_a = bin2bcd(conv_bin_a);
  assign conv_bcd_b = bin2bcd(conv_bin_b);

  bcd_display_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_a), .conv_bin(conv_bin_a), .conv_bcd(conv_bcd_a),
    .an(an_a), .seg(seg_a), .ovf(ovf_a));

  bcd_display_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_b), .conv_bin(conv_bin_b), .conv_bcd(conv_bcd_b),
    .an(an_b), .seg(seg_b), .ovf(ovf_b));

  function automatic logic [6:0] exp_seg(input logic [39:0] bcd, input logic ov,
                                         input int unsigned i, input bit blz);
    logic [3:0]  n;
    logic [31:0] low;
    if (ov) return 7'h3F;
    low = bcd[31:0];
    n   = bcd[4*i +: 4];
    if (n > 4'd9) return 7'h3F;
    if (blz && i != 0 && (low >> (4*i)) == 32'd0) return 7'h7F;
    return SEGTAB[n];
  endfunction

  // Reference model state
  int unsigned   m_div, m_idx, m_state;
  logic [39:0]   m_disp;
  logic          m_ovf;
  logic [31:0]   m_bin;
  logic [ND-1:0] m_an;
  logic [6:0]    m_seg_a, m_seg_b;
  logic [39:0]   sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_div = 0; m_idx = 0; m_state = 0;
    m_disp = '0; m_ovf = 1'b0; m_bin = '0;
    m_an = '1; m_seg_a = 7'h7F; m_seg_b = 7'h7F;
    sb.delete();
  endtask

  task automatic check_outputs();
    chk("req_ready_a", 64'(req_ready_a), 64'(m_state == 0));
    chk("req_ready_b", 64'(req_ready_b), 64'(m_state == 0));
    chk("conv_bin",    64'(conv_bin_a),  64'(m_bin));
    chk("an_a",        64'(an_a),        64'(m_an));
    chk("an_b",        64'(an_b),        64'(m_an));
    chk("seg_a",       64'(seg_a),       64'(m_seg_a));
    chk("seg_b",       64'(seg_b),       64'(m_seg_b));
    chk("ovf_a",       64'(ovf_a),       64'(m_ovf));
    chk("ovf_b",       64'(ovf_b),       64'(m_ovf));
  endtask

  task automatic check_reset_values();
    chk("rst_ready",  64'(req_ready_a), 64'(1));
    chk("rst_convbin", 64'(conv_bin_a), 64'(0));
    chk("rst_an",     64'(an_a),        64'(8'hFF));
    chk("rst_seg",    64'(seg_a),       64'(7'h7F));
    chk("rst_seg_b",  64'(seg_b),       64'(7'h7F));
    chk("rst_ovf",    64'(ovf_a),       64'(0));
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    m_an    = ~(ND'(1) << m_idx);
    m_seg_a = exp_seg(m_disp, m_ovf, m_idx, 1'b1);
    m_seg_b = exp_seg(m_disp, m_ovf, m_idx, 1'b0);
    if (m_div == SD - 1) begin
      m_div = 0;
      m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
    end else begin
      m_div++;
    end
    case (m_state)
      0: if (req_valid) begin
           sb.push_back(bin2bcd(req_data));
           m_bin   = req_data;
           m_state = 1;
         end
      1: m_state = 2;
      default: begin
        if (sb.size() > 0) m_disp = sb.pop_front();
        m_ovf   = |m_disp[39:32];
        m_state = 0;
      end
    endcase
    #1;
    check_outputs();
  endtask

  task automatic send(input logic [31:0] v);
    req_valid = 1'b1;
    req_data  = v;
    tick();
    req_valid = 1'b0;
    req_data  = $urandom;
  endtask

  logic [31:0] held [7];

  initial begin
    held = '{32'd1, 32'd77, 32'd88, 32'd2, 32'd99, 32'd66, 32'd3};
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_data  = '0;
    model_reset();
    #12;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) tick();

    send(32'd12345);
    repeat (36) tick();

    send(32'd907);
    repeat (36) tick();

    send(32'hFFFF_FFFF);
    repeat (36) tick();
    send(32'd99999999);
    repeat (36) tick();

    // Valid held high; only every third cycle's data may be taken.
    req_valid = 1'b1;
    foreach (held[i]) begin
      req_data = held[i];
      tick();
    end
    req_valid = 1'b0;
    repeat (36) tick();

    // Reset while 555 is in SETTLE.
    send(32'd555);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_values();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_values();
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_display_ctrl.md
# bcd_display_ctrl

Sequencing controller that shares the combinational 32-bit binary-to-BCD converter with a multiplexed seven-segment display. It accepts a 32-bit binary value over a valid/ready handshake, drives the external converter instance, captures its 40-bit BCD result after a fixed two-cycle settle window, and time-multiplexes the captured digits onto common-anode digit/segment pins with leading-zero blanking. It sits between the CPU's memory-mapped display register and the board's display pins.

## Interface
- NUM_DIGITS, 8, number of physical digits driven (1..10).
- SCAN_DIV, 50000, clock cycles each digit stays enabled (≥2).
- BLANK_LZ, 1, 1 = blank leading zeros, 0 = show all digits.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  new value offered.
- req_data  in  32  unsigned binary value.
- req_ready  out  1  controller can accept a value.
- conv_bin  out  32  drives converter `bin` input.
- conv_bcd  in  40  converter `bcd` output, digit k at [4k+3:4k].
- an  out  NUM_DIGITS  digit enables, active-low, one-hot.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- ovf  out  1  captured value needs more than NUM_DIGITS digits.

## Operation
- FSM states IDLE, SETTLE, CAPTURE. Reset → IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready, bin_q<=req_data, go SETTLE. Otherwise stay.
- SETTLE: req_ready=0; conv_bin=bin_q held stable; unconditional → CAPTURE.
- CAPTURE: req_ready=0; at end of cycle disp_bcd<=conv_bcd, ovf<=(any nibble at index ≥NUM_DIGITS nonzero); → IDLE.
- conv_bin is bin_q in all states (register-driven, never combinational from req_data). Converter path is a 2-cycle multicycle path from bin_q to disp_bcd.
- req_valid ignored outside IDLE; req_data sampled only on handshake.
- Scan: div counts 0..SCAN_DIV-1; on wrap, idx<=(idx==NUM_DIGITS-1)?0:idx+1. Scan runs continuously, independent of FSM.
- Digit i (i≥1) blank when BLANK_LZ=1 and nibbles i..NUM_DIGITS-1 of disp_bcd all zero; digit 0 never blank.
- ovf=1 overrides: every digit shows dash.
- Nibble >9 shows dash (defensive; converter should never produce it).
- Segment codes (hex, {g..a}): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10, blank:7F, dash:3F.
- an and seg are registered: each cycle an<=~(1<<idx), seg<=code(digit idx).

## Timing
- Reset values: req_ready=1, conv_bin=0, an=all ones, seg=7F, ovf=0; internal bin_q=0, disp_bcd=0, div=0, idx=0.
- First cycle after reset release: an=~1, seg=40 (shows "0").
- Handshake in cycle T: conv_bin=new value from T+1; SETTLE T+1, CAPTURE T+2; disp_bcd/ovf new from T+3; req_ready=1 from T+3; an/seg reflect new value from T+4 for the currently scanned digit.
- Throughput: one value per 3 cycles with req_valid held high.
- disp_bcd updates mid-scan take effect at the next registered seg update; no wait for a digit boundary.
- Simultaneous scan wrap and CAPTURE: both apply; the next seg uses new idx and new disp_bcd.
- Reset asserted mid-operation: FSM → IDLE immediately, pending value discarded, display reverts to "0".
- SCAN_DIV wrap: idx advances every SCAN_DIV cycles; full refresh period NUM_DIGITS×SCAN_DIV cycles.

## Test plan
- Reset, no request, SCAN_DIV=4, NUM_DIGITS=8 → an cycles FE,FD,…,7F every 4 cycles; seg=40 on digit 0, 7F on digits 1–7; ovf=0.
- Send 12345 at T → req_ready low T+1..T+2, high T+3; digits 0–4 show 5,4,3,2,1 (12,19,30,24,79); digits 5–7 = 7F.
- BLANK_LZ=0, send 907 → digits show 7,0,9,0,0,0,0,0 (78,40,10,40,…); internal zeros not blanked with BLANK_LZ=1 either (digit 1 = 40).
- NUM_DIGITS=8, send 0xFFFFFFFF (4294967295) → ovf=1, every digit seg=3F; then send 99999999 → ovf=0, all eight digits seg=10.
- req_valid held high with values 1,2,3 → accepted only at T, T+3, T+6; final display "3"; req_data changes during SETTLE/CAPTURE have no effect.
- Assert rst_n low during SETTLE of value 555 → after release req_ready=1, an=all-ones then ~1, display "0", no capture of 555.
